// File: rtl/bitwise_serial_unit.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_serial_unit
// Description : Bit-serial AND/OR unit. Operands A and B arrive one bit per
//               cycle, LSB first, on a valid/ready stream. Beat i writes bit i
//               of the result vectors directly; the two reduction flags
//               accumulate per beat. A complete frame is presented on a
//               valid/ready result port until the consumer takes it.
//
// Ports       : clk              - rising-edge clock
//               rst_n            - synchronous reset, active-low
//               in_valid         - a_bit/b_bit carry a valid beat
//               in_ready         - unit accepts a beat (state != DONE)
//               a_bit, b_bit     - current operand bits, LSB first
//               abort            - discard the partial frame (ignored in DONE)
//               res_valid        - result registers hold a complete frame
//               res_ready        - consumer takes the result
//               and_result       - A & B
//               or_result        - A | B
//               or_reduction_a   - |A
//               and_reduction_or - &(A & B)
//               xor_result       - A ^ B (only with BITSER_XOR_EN)
//               busy             - frame in progress (SHIFT)
//
// Config      : define BITSER_XOR_EN to add the xor_result output.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_serial_unit #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] and_result,
    output logic [WIDTH-1:0] or_result,
    output logic             or_reduction_a,
    output logic             and_reduction_or,
`ifdef BITSER_XOR_EN
    output logic [WIDTH-1:0] xor_result,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic             r_or_red;
    logic             r_and_red;
`ifdef BITSER_XOR_EN
    logic [WIDTH-1:0] r_xor;
`endif

    logic w_in_ready;

    // Ready depends on state only, so upstream never sees a combinational
    // path from its own valid back to ready.
    assign w_in_ready = (r_state != c_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_and     <= '0;
            r_or      <= '0;
            r_or_red  <= 1'b0;
            r_and_red <= 1'b0;
`ifdef BITSER_XOR_EN
            r_xor     <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (abort) begin
                        r_cnt <= '0;
                    end else if (in_valid) begin
                        // First beat re-seeds both reduction accumulators.
                        r_and[0]  <= a_bit & b_bit;
                        r_or[0]   <= a_bit | b_bit;
`ifdef BITSER_XOR_EN
                        r_xor[0]  <= a_bit ^ b_bit;
`endif
                        r_or_red  <= a_bit;
                        r_and_red <= a_bit & b_bit;
                        r_cnt     <= CW'(1);
                        r_state   <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (abort) begin
                        // Abort wins over a beat presented in the same cycle.
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else if (in_valid) begin
                        r_and[r_cnt] <= a_bit & b_bit;
                        r_or[r_cnt]  <= a_bit | b_bit;
`ifdef BITSER_XOR_EN
                        r_xor[r_cnt] <= a_bit ^ b_bit;
`endif
                        r_or_red     <= r_or_red | a_bit;
                        r_and_red    <= r_and_red & a_bit & b_bit;
                        if (r_cnt == c_LAST) begin
                            r_cnt   <= '0;
                            r_state <= c_DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                c_DONE: begin
                    // Result registers are left untouched on exit.
                    if (res_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready         = w_in_ready;
    assign res_valid        = (r_state == c_DONE);
    assign busy             = (r_state == c_SHIFT);
    assign and_result       = r_and;
    assign or_result        = r_or;
    assign or_reduction_a   = r_or_red;
    assign and_reduction_or = r_and_red;
`ifdef BITSER_XOR_EN
    assign xor_result       = r_xor;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_serial_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_serial_unit
// Description : Self-checking bench for bitwise_serial_unit. A frame-level
//               model collects operand bits into vectors and derives the
//               expected results with whole-vector operators; a negedge
//               process compares handshake/status outputs every cycle and the
//               result outputs whenever a frame is being presented. Directed
//               frames carry literal expectations, followed by random frames
//               with gaps, aborts and result stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_serial_unit;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         a_bit;
    logic         b_bit;
    logic         abort;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] and_result;
    logic [W-1:0] or_result;
    logic         or_reduction_a;
    logic         and_reduction_or;
`ifdef BITSER_XOR_EN
    logic [W-1:0] xor_result;
`endif
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitwise_serial_unit #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a_bit            (a_bit),
        .b_bit            (b_bit),
        .abort            (abort),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .and_result       (and_result),
        .or_result        (or_result),
        .or_reduction_a   (or_reduction_a),
        .and_reduction_or (and_reduction_or),
`ifdef BITSER_XOR_EN
        .xor_result       (xor_result),
`endif
        .busy             (busy)
    );

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    typedef enum int {PH_IDLE, PH_COLLECT, PH_PRESENT} phase_t;
    phase_t       m_phase = PH_IDLE;
    bit           m_live  = 1'b0;
    logic         qa[$];
    logic         qb[$];
    logic [W-1:0] e_and, e_or, e_xor;
    logic         e_orred, e_andred;

    always @(posedge clk) begin
        logic [W-1:0] va, vb;
        if (!rst_n) begin
            m_phase = PH_IDLE;
            qa.delete();
            qb.delete();
            m_live  = 1'b1;
        end else if (m_phase == PH_PRESENT) begin
            if (res_ready) m_phase = PH_IDLE;
        end else if (abort) begin
            m_phase = PH_IDLE;
            qa.delete();
            qb.delete();
        end else if (in_valid) begin
            qa.push_back(a_bit);
            qb.push_back(b_bit);
            if (qa.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    va[i] = qa[i];
                    vb[i] = qb[i];
                end
                e_and    = va & vb;
                e_or     = va | vb;
                e_xor    = va ^ vb;
                e_orred  = |va;
                e_andred = &(va & vb);
                qa.delete();
                qb.delete();
                m_phase  = PH_PRESENT;
            end else begin
                m_phase = PH_COLLECT;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live && rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase != PH_PRESENT));
            chk("busy", 32'(busy), 32'(m_phase == PH_COLLECT));
            chk("res_valid", 32'(res_valid), 32'(m_phase == PH_PRESENT));
            if (m_phase == PH_PRESENT) begin
                chk("and_result", 32'(and_result), 32'(e_and));
                chk("or_result", 32'(or_result), 32'(e_or));
                chk("or_reduction_a", 32'(or_reduction_a), 32'(e_orred));
                chk("and_reduction_or", 32'(and_reduction_or), 32'(e_andred));
`ifdef BITSER_XOR_EN
                chk("xor_result", 32'(xor_result), 32'(e_xor));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic a, input logic b);
        int t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        chk("beat_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_bit    = a;
        b_bit    = b;
        step();
        in_valid = 1'b0;
        a_bit    = 1'($urandom);
        b_bit    = 1'($urandom);
    endtask

    task automatic send_frame(input logic [W-1:0] va, input logic [W-1:0] vb, input int maxgap);
        for (int i = 0; i < W; i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
            send_beat(va[i], vb[i]);
        end
    endtask

    task automatic release_result();
        in_valid  = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_and", 32'(and_result), 32'd0);
        chk("rst_or", 32'(or_result), 32'd0);
        chk("rst_orred", 32'(or_reduction_a), 32'd0);
        chk("rst_andred", 32'(and_reduction_or), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // A=101, B=110, back-to-back
        send_frame(3'b101, 3'b110, 0);
        chk("f1_valid", 32'(res_valid), 32'd1);
        chk("f1_and", 32'(and_result), 32'b100);
        chk("f1_or", 32'(or_result), 32'b111);
        chk("f1_orred", 32'(or_reduction_a), 32'd1);
        chk("f1_andred", 32'(and_reduction_or), 32'd0);
`ifdef BITSER_XOR_EN
        chk("f1_xor", 32'(xor_result), 32'b011);
`endif
        release_result();

        // A=111, B=111
        send_frame(3'b111, 3'b111, 0);
        chk("f2_and", 32'(and_result), 32'b111);
        chk("f2_or", 32'(or_result), 32'b111);
        chk("f2_andred", 32'(and_reduction_or), 32'd1);
        release_result();

        // A=000, B=101 with gaps
        send_frame(3'b000, 3'b101, 3);
        chk("f3_or", 32'(or_result), 32'b101);
        chk("f3_orred", 32'(or_reduction_a), 32'd0);
        chk("f3_and", 32'(and_result), 32'b000);

        // Result stall with in_valid pulses, then release
        release_result();
        send_frame(3'b101, 3'b110, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a_bit    = 1'b1;
            b_bit    = 1'b1;
            step();
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_and", 32'(and_result), 32'b100);
        end
        release_result();
        chk("rel_valid", 32'(res_valid), 32'd0);
        chk("rel_ready", 32'(in_ready), 32'd1);
        send_frame(3'b011, 3'b010, 0);
        chk("post_stall_and", 32'(and_result), 32'b010);
        release_result();

        // Abort after 2 beats (a beat presented with abort is dropped)
        send_beat(1'b1, 1'b1);
        send_beat(1'b1, 1'b1);
        abort    = 1'b1;
        in_valid = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        send_frame(3'b011, 3'b001, 0);
        chk("abort_next_and", 32'(and_result), 32'b001);
        chk("abort_next_orred", 32'(or_reduction_a), 32'd1);
        release_result();

        // Reset after 2 beats
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_and", 32'(and_result), 32'd0);
        send_frame(3'b011, 3'b001, 0);
        chk("mrst_next_and", 32'(and_result), 32'b001);
        release_result();

        // Random frames with gaps, aborts and stalls
        for (int f = 0; f < 60; f++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                int k = $urandom_range(0, W - 1);
                for (int j = 0; j < k; j++) send_beat(1'($urandom), 1'($urandom));
                abort    = 1'b1;
                in_valid = 1'($urandom);
                step();
                abort    = 1'b0;
                in_valid = 1'b0;
            end
            send_frame(ra, rb, 2);
            repeat ($urandom_range(0, 4)) begin
                in_valid = 1'($urandom);
                abort    = 1'($urandom);
                a_bit    = 1'($urandom);
                b_bit    = 1'($urandom);
                step();
            end
            release_result();
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
